pmd_rompack_loader: RTL and testbench

- Parametrised multi-slot ROM-pack loader. Takes the HPS ioctl download stream and writes bytes into one of SLOTS ROM-pack memories through a ready/valid write port.
- Buffers writes in a 2-entry FIFO, checks address range, and computes pack size and an 8-bit checksum.
- Optionally pads the unused tail of the slot with 0xFF.
- Sits between hps_io and the PMD85 core ROM-pack memory. Replaces the single fixed "Load to ROM Pack" path.

---
 rtl/pmd_rompack_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_pmd_rompack_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmd_rompack_loader.sv
// Multi-slot ROM-pack loader: ioctl bytes -> 2-entry queue -> slot memory, optional 0xFF tail fill.
// 1-cycle ioctl_wr->mem_we latency; mem_we holds until mem_ready, bytes arriving on a full queue are dropped.
module pmd_rompack_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] dat_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
endmodule

module pmd_rompack_loader #(
    parameter int  ADDR_W     = 16,
    parameter int  SLOTS      = 2,
    parameter int  INDEX_BASE = 1,
    parameter int  FILL_EN    = 1,
    localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic                     mem_we,
    input  logic                     mem_ready,
    output logic [SLOT_W+ADDR_W-1:0] mem_addr,
    output logic [7:0]               mem_din,
    output logic                     load_busy,
    output logic                     load_done,
    output logic                     load_error,
    output logic [SLOT_W-1:0]        load_slot,
    output logic [ADDR_W:0]          pack_size,
    output logic [7:0]               checksum
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              dl_prev_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   size_q, size_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;

    logic [7:0]        slot_idx;
    logic              slot_ok;
    logic              dl_rise;
    logic              dl_fall;
    logic              in_range;
    logic [ADDR_W:0]   wr_end;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_off;
    logic [7:0]        head_dat;
    logic              filling;

    assign slot_idx = ioctl_index - 8'(INDEX_BASE);
    assign slot_ok  = 32'(slot_idx) < 32'(SLOTS);
    assign dl_rise  = ioctl_download & ~dl_prev_q;
    assign dl_fall  = ~ioctl_download & dl_prev_q;
    assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
    assign wr_end   = {1'b0, ioctl_addr[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};

    assign fifo_push = (state_q == S_LOAD) && ioctl_wr && in_range && !fifo_full;
    assign fifo_pop  = !fifo_empty && mem_ready;
    assign filling   = (state_q == S_FILL);

    pmd_rompack_fifo2 #(.W(ADDR_W + 8)) u_fifo (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .dat_i   ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  ({head_off, head_dat})
    );

    // Queued bytes always go out before fill; the queue is empty by the time FILL starts.
    always_comb begin
        mem_we   = !fifo_empty || filling;
        mem_addr = '0;
        mem_din  = 8'h00;
        if (!fifo_empty) begin
            mem_addr = {slot_q, head_off};
            mem_din  = head_dat;
        end else if (filling) begin
            mem_addr = {slot_q, fill_ptr_q};
            mem_din  = 8'hFF;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        err_d      = err_q;
        size_d     = size_q;
        sum_d      = sum_q;
        fill_ptr_d = fill_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (dl_rise) begin
                    if (slot_ok) begin
                        state_d = S_LOAD;
                        slot_d  = slot_idx[SLOT_W-1:0];
                        err_d   = 1'b0;
                        size_d  = '0;
                        sum_d   = 8'h00;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (ioctl_wr) begin
                    if (!in_range || fifo_full) begin
                        err_d = 1'b1;
                    end else begin
                        sum_d = sum_q + ioctl_dout;
                        if (wr_end > size_q) begin
                            size_d = wr_end;
                        end
                    end
                end
                if (dl_fall) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fifo_empty) begin
                    if ((FILL_EN != 0) && !size_q[ADDR_W]) begin
                        state_d    = S_FILL;
                        fill_ptr_d = size_q[ADDR_W-1:0];
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FILL: begin
                if (mem_ready) begin
                    if (&fill_ptr_q) begin
                        state_d = S_DONE;
                    end else begin
                        fill_ptr_d = fill_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dl_prev_q  <= 1'b0;
            slot_q     <= '0;
            err_q      <= 1'b0;
            size_q     <= '0;
            sum_q      <= 8'h00;
            fill_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            dl_prev_q  <= ioctl_download;
            slot_q     <= slot_d;
            err_q      <= err_d;
            size_q     <= size_d;
            sum_q      <= sum_d;
            fill_ptr_q <= fill_ptr_d;
        end
    end

    assign load_busy  = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_FILL);
    assign load_done  = (state_q == S_DONE);
    assign load_error = err_q;
    assign load_slot  = slot_q;
    assign pack_size  = size_q;
    assign checksum   = sum_q;
endmodule

// File: tb/tb_pmd_rompack_loader.sv
// Bench: two loaders (fill on / fill off) share one ioctl stream; writes are compared to a queue model.
module tb_pmd_rompack_loader;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset, ioctl_download, ioctl_wr, mem_ready;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;

    logic       f_we, f_busy, f_done, f_err, f_slot;
    logic [4:0] f_maddr, f_size;
    logic [7:0] f_din, f_sum;
    logic       n_we, n_busy, n_done, n_err, n_slot;
    logic [4:0] n_maddr, n_size;
    logic [7:0] n_din, n_sum;

    pmd_rompack_loader #(.ADDR_W(4), .SLOTS(2), .INDEX_BASE(1), .FILL_EN(1)) u_fill (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .mem_we(f_we), .mem_ready(mem_ready), .mem_addr(f_maddr), .mem_din(f_din),
        .load_busy(f_busy), .load_done(f_done), .load_error(f_err), .load_slot(f_slot),
        .pack_size(f_size), .checksum(f_sum));

    pmd_rompack_loader #(.ADDR_W(4), .SLOTS(2), .INDEX_BASE(1), .FILL_EN(0)) u_nofill (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .mem_we(n_we), .mem_ready(mem_ready), .mem_addr(n_maddr), .mem_din(n_din),
        .load_busy(n_busy), .load_done(n_done), .load_error(n_err), .load_slot(n_slot),
        .pack_size(n_size), .checksum(n_sum));

    int n_tests = 0;
    int n_fail  = 0;

    logic [12:0] fw_q[$], nw_q[$], exp_q[$];
    int          f_done_cnt, n_done_cnt, f_wr_at_done, n_wr_at_done;
    int          pend, exp_size, cur_slot;
    logic [7:0]  exp_sum;
    logic        exp_err;
    int          st_addr[$];
    logic [7:0]  st_data[$];

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (f_we && mem_ready) fw_q.push_back({f_maddr, f_din});
            if (n_we && mem_ready) nw_q.push_back({n_maddr, n_din});
            if (f_done) begin f_done_cnt++; f_wr_at_done = fw_q.size(); end
            if (n_done) begin n_done_cnt++; n_wr_at_done = nw_q.size(); end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_mon();
        fw_q.delete(); nw_q.delete();
        f_done_cnt = 0; n_done_cnt = 0; f_wr_at_done = 0; n_wr_at_done = 0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_f_we"},   32'(f_we),    32'd0);
        chk({tag, "_f_addr"}, 32'(f_maddr), 32'd0);
        chk({tag, "_f_din"},  32'(f_din),   32'd0);
        chk({tag, "_f_busy"}, 32'(f_busy),  32'd0);
        chk({tag, "_f_done"}, 32'(f_done),  32'd0);
        chk({tag, "_f_err"},  32'(f_err),   32'd0);
        chk({tag, "_f_slot"}, 32'(f_slot),  32'd0);
        chk({tag, "_f_size"}, 32'(f_size),  32'd0);
        chk({tag, "_f_sum"},  32'(f_sum),   32'd0);
        chk({tag, "_n_we"},   32'(n_we),    32'd0);
        chk({tag, "_n_busy"}, 32'(n_busy),  32'd0);
        chk({tag, "_n_size"}, 32'(n_size),  32'd0);
        chk({tag, "_n_sum"},  32'(n_sum),   32'd0);
    endtask

    // One clock with random mem_ready; the model tracks pending bytes to decide what is accepted.
    task automatic step(input int rdy_pct);
        logic take;
        mem_ready = ($urandom_range(99) < rdy_pct);
        take = 1'b0;
        if (ioctl_wr && ioctl_download) begin
            take = (ioctl_addr < 25'd16) && (pend < 2);
            if (!take) begin
                exp_err = 1'b1;
            end else begin
                exp_q.push_back({5'(cur_slot * 16 + int'(ioctl_addr[3:0])), ioctl_dout});
                exp_sum = exp_sum + ioctl_dout;
                if (int'(ioctl_addr) + 1 > exp_size) exp_size = int'(ioctl_addr) + 1;
            end
        end
        if (pend > 0 && mem_ready) pend--;
        if (take) pend++;
        tick();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        mem_ready = 1'b1;
        while ((f_busy || n_busy) && k < 200) begin tick(); k++; end
        chk("idle_timeout", 32'(k < 200), 32'd1);
        tick(); tick();
    endtask

    task automatic cmp_list(input string nm, input logic [12:0] got[$], input logic [12:0] exp[$]);
        chk({nm, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic run_load(input logic [7:0] idx, input int rdy_pct);
        logic [12:0] exp_f[$];
        int k;
        clear_mon();
        pend = 0; exp_q.delete(); exp_sum = 8'h00; exp_size = 0; exp_err = 1'b0;
        cur_slot = int'(idx) - 1;
        ioctl_index = idx; ioctl_download = 1'b1;
        step(rdy_pct);
        for (int i = 0; i < st_addr.size(); i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(st_addr[i]); ioctl_dout = st_data[i];
            step(rdy_pct);
            ioctl_wr = 1'b0;
            repeat ($urandom_range(0, 2)) step(rdy_pct);
        end
        step(rdy_pct);
        ioctl_download = 1'b0;
        k = 0;
        while ((f_done_cnt == 0 || n_done_cnt == 0) && k < 300) begin step(rdy_pct); k++; end
        chk("load_timeout", 32'(k < 300), 32'd1);
        repeat (3) step(100);
        exp_f = exp_q;
        for (int off = exp_size; off < 16; off++) exp_f.push_back({5'(cur_slot * 16 + off), 8'hFF});
        cmp_list("nofill_writes", nw_q, exp_q);
        cmp_list("fill_writes", fw_q, exp_f);
        chk("n_sum",  32'(n_sum),  32'(exp_sum));
        chk("f_sum",  32'(f_sum),  32'(exp_sum));
        chk("n_size", 32'(n_size), 32'(exp_size));
        chk("f_size", 32'(f_size), 32'(exp_size));
        chk("n_err",  32'(n_err),  32'(exp_err));
        chk("f_err",  32'(f_err),  32'(exp_err));
        chk("n_slot", 32'(n_slot), 32'(cur_slot));
        chk("f_slot", 32'(f_slot), 32'(cur_slot));
        chk("n_done_pulses", 32'(n_done_cnt), 32'd1);
        chk("f_done_pulses", 32'(f_done_cnt), 32'd1);
        chk("n_done_after_writes", 32'(n_wr_at_done), 32'(exp_q.size()));
        chk("f_done_after_writes", 32'(f_wr_at_done), 32'(exp_f.size()));
    endtask

    typedef struct {
        logic dl; logic wr; logic [24:0] addr; logic [7:0] dout;
        logic we; logic [4:0] maddr; logic [7:0] din;
        logic busy; logic done; logic err; logic [4:0] size; logic [7:0] sum;
    } vec_t;
    vec_t tv[8];

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int k;
        int pct_tab[3];
        tv[0] = '{1'b1, 1'b0, 25'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00};
        tv[1] = '{1'b1, 1'b1, 25'd0, 8'h11, 1'b1, 5'd0, 8'h11, 1'b1, 1'b0, 1'b0, 5'd1, 8'h11};
        tv[2] = '{1'b1, 1'b1, 25'd1, 8'h22, 1'b1, 5'd1, 8'h22, 1'b1, 1'b0, 1'b0, 5'd2, 8'h33};
        tv[3] = '{1'b1, 1'b1, 25'd2, 8'h33, 1'b1, 5'd2, 8'h33, 1'b1, 1'b0, 1'b0, 5'd3, 8'h66};
        tv[4] = '{1'b1, 1'b1, 25'd3, 8'h44, 1'b1, 5'd3, 8'h44, 1'b1, 1'b0, 1'b0, 5'd4, 8'hAA};
        tv[5] = '{1'b0, 1'b0, 25'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd4, 8'hAA};
        tv[6] = '{1'b0, 1'b0, 25'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd4, 8'hAA};
        tv[7] = '{1'b0, 1'b0, 25'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd4, 8'hAA};
        pct_tab = '{100, 70, 40};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; mem_ready = 1'b1;
        ioctl_index = 8'd1; ioctl_addr = 25'd0; ioctl_dout = 8'h00;
        clear_mon();
        repeat (3) tick();
        chk_outs_zero("reset");
        reset = 1'b0;
        tick();

        // Four-byte load into slot 0, fill disabled instance checked cycle by cycle.
        for (int i = 0; i < 8; i++) begin
            ioctl_download = tv[i].dl; ioctl_wr = tv[i].wr;
            ioctl_addr = tv[i].addr; ioctl_dout = tv[i].dout;
            tick();
            chk($sformatf("tv%0d_we", i), 32'(n_we), 32'(tv[i].we));
            if (tv[i].we) begin
                chk($sformatf("tv%0d_addr", i), 32'(n_maddr), 32'(tv[i].maddr));
                chk($sformatf("tv%0d_din", i),  32'(n_din),   32'(tv[i].din));
            end
            chk($sformatf("tv%0d_busy", i), 32'(n_busy), 32'(tv[i].busy));
            chk($sformatf("tv%0d_done", i), 32'(n_done), 32'(tv[i].done));
            chk($sformatf("tv%0d_err", i),  32'(n_err),  32'(tv[i].err));
            chk($sformatf("tv%0d_size", i), 32'(n_size), 32'(tv[i].size));
            chk($sformatf("tv%0d_sum", i),  32'(n_sum),  32'(tv[i].sum));
        end
        ioctl_wr = 1'b0;
        wait_idle();

        // Same stream through the model: fill instance must pad offsets 4..15.
        st_addr = '{0, 1, 2, 3};
        st_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(8'd1, 100);
        chk("fill_sum_aa", 32'(f_sum), 32'hAA);
        chk("fill_total_writes", 32'(fw_q.size()), 32'd16);

        // Stalled memory: request must hold steady for slot 1 offset 0.
        clear_mon();
        mem_ready = 1'b0; ioctl_index = 8'd2; ioctl_download = 1'b1;
        tick();
        ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h5A;
        tick();
        ioctl_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_we",   32'(n_we),    32'd1);
            chk("stall_addr", 32'(n_maddr), 32'h10);
            chk("stall_din",  32'(n_din),   32'h5A);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        chk("stall_accepted", 32'(nw_q.size()), 32'd1);
        chk("stall_we_drop",  32'(n_we), 32'd0);
        chk("stall_slot",     32'(n_slot), 32'd1);
        ioctl_download = 1'b0;
        wait_idle();

        // Index outside slot range: error only, no activity.
        clear_mon();
        ioctl_index = 8'd9; ioctl_download = 1'b1;
        tick();
        chk("badidx_err_n", 32'(n_err), 32'd1);
        chk("badidx_err_f", 32'(f_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1);
            tick();
            chk("badidx_we",   32'(n_we | f_we), 32'd0);
            chk("badidx_busy", 32'(n_busy | f_busy), 32'd0);
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        repeat (3) tick();
        chk("badidx_done", 32'(n_done_cnt + f_done_cnt), 32'd0);
        chk("badidx_writes", 32'(nw_q.size() + fw_q.size()), 32'd0);

        // Out-of-range address dropped, later in-range byte kept.
        st_addr = '{16, 2};
        st_data = '{8'hEE, 8'h5C};
        run_load(8'd1, 100);
        chk("ovf_size", 32'(n_size), 32'd3);
        chk("ovf_err",  32'(n_err),  32'd1);

        // Reset in the middle of padding.
        clear_mon();
        mem_ready = 1'b1; ioctl_index = 8'd2; ioctl_download = 1'b1;
        tick();
        ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h77;
        tick();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        k = 0;
        while (n_done_cnt == 0 && k < 50) begin tick(); k++; end
        chk("prefill_timeout", 32'(k < 50), 32'd1);
        tick();
        chk("fill_active", 32'(f_busy & f_we), 32'd1);
        reset = 1'b1;
        tick();
        chk_outs_zero("midfill_reset");
        reset = 1'b0;
        tick();

        st_addr = '{5, 0, 9};
        st_data = '{8'h01, 8'h02, 8'h03};
        run_load(8'd1, 100);

        for (int r = 0; r < 15; r++) begin
            int n;
            n = $urandom_range(1, 10);
            st_addr.delete(); st_data.delete();
            for (int i = 0; i < n; i++) begin
                st_addr.push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 40))
                                                              : int'($urandom_range(0, 15)));
                st_data.push_back(8'($urandom));
            end
            run_load(8'($urandom_range(1, 2)), pct_tab[r % 3]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
